ring_counter_monitor: RTL

Receive-side checker for the one-hot ring counter bus. It samples an N-bit ring count each enabled cycle and decodes it to a binary index. It verifies that each sample is exactly one-hot and is the correct rotation of the previous sample. It acquires and holds sequence lock, flags errors and keeps a saturating error count. It sits downstream of any ring-counter-driven sequencer as a protocol monitor and index decoder.

---
 rtl/ring_counter_monitor.sv | 91 +++++++++
 1 files changed

// File: rtl/ring_counter_monitor.sv
// ring_counter_monitor: checks a one-hot ring count for correct rotation, decodes its index,
// tracks sequence lock and keeps a saturating error count.
module ring_counter_monitor #(
    parameter int N        = 4,
    parameter int DIR      = 0,
    parameter int LOCK_CNT = 2,
    parameter int ERR_W    = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic [N-1:0]         ring_in,
    input  logic                 clr_err,
    output logic [$clog2(N)-1:0] idx,
    output logic                 onehot_ok,
    output logic                 locked,
    output logic                 seq_err,
    output logic                 wrap,
    output logic [ERR_W-1:0]     err_cnt
);
    localparam int IW = $clog2(N);
    localparam int CW = $clog2(LOCK_CNT + 1);
    localparam int WB = (DIR == 0) ? 0 : N - 1;

    typedef enum logic [1:0] {IDLE, ACQ, LOCK} state_t;

    state_t        state;
    logic [CW-1:0] good_cnt;
    logic [N-1:0]  prev;
    logic [N-1:0]  expect_v;
    logic [IW-1:0] pos;
    logic          oh;
    logic          good;
    logic          err;

    always_comb begin
        pos = '0;
        for (int i = 0; i < N; i++)
            if (ring_in[i]) pos = pos | IW'(i);
    end

    assign oh       = (ring_in != '0) && ((ring_in & (ring_in - N'(1))) == '0);
    assign expect_v = (DIR == 0) ? {prev[N-2:0], prev[N-1]} : {prev[0], prev[N-1:1]};
    assign good     = oh && (ring_in == expect_v);
    assign err      = en && (state == LOCK) && !good;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            good_cnt  <= '0;
            prev      <= '0;
            idx       <= '0;
            onehot_ok <= 1'b0;
            locked    <= 1'b0;
            seq_err   <= 1'b0;
            wrap      <= 1'b0;
            err_cnt   <= '0;
        end else begin
            seq_err <= err;
            wrap    <= en && (state == LOCK) && good && ring_in[WB];
            if (clr_err)
                err_cnt <= err ? ERR_W'(1) : '0;
            else if (err && err_cnt != '1)
                err_cnt <= err_cnt + ERR_W'(1);
            if (en) begin
                onehot_ok <= oh;
                if (oh) begin
                    idx  <= pos;
                    prev <= ring_in;
                end
                // A held or skipped one-hot value restarts acquisition on the new reference
                if (!oh) begin
                    state    <= IDLE;
                    locked   <= 1'b0;
                    good_cnt <= '0;
                end else if (state == IDLE || !good) begin
                    state    <= ACQ;
                    locked   <= 1'b0;
                    good_cnt <= '0;
                end else if (state == ACQ) begin
                    if (good_cnt == CW'(LOCK_CNT - 1)) begin
                        state  <= LOCK;
                        locked <= 1'b1;
                    end else begin
                        good_cnt <= good_cnt + CW'(1);
                    end
                end
            end
        end
    end
endmodule
